unipi_se_pwm_ramp: RTL
======================

# unipi_se_pwm_ramp

Duty-cycle ramp sequencer that sits between the Nios II and one PWM slave (CONTROL/PERIOD/COMPARE register map). The CPU programs a target compare value, a step size and a step interval through an Avalon-MM slave port. The block then drives the PWM slave's write port as an Avalon-MM master, moving COMPARE one bounded step at a time. It also optionally enables the PWM at ramp start, and raises a done interrupt when the target is reached.

## Interface
- RESET_CURRENT, 0: reset value of the internal current-compare register
- RESET_INTERVAL, 1000: reset value of INTERVAL, in clocks
- PWM_CTRL_ADDR, 0: master address of the PWM CONTROL register
- PWM_CMP_ADDR, 2: master address of the PWM COMPARE register
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  slave register index
- read  in  1  slave read strobe
- write  in  1  slave write strobe
- writedata  in  32  slave write data
- readdata  out  32  slave read data, registered
- irq  out  1  level interrupt: done flag AND irq_en
- m_address  out  2  master address toward the PWM slave
- m_write  out  1  master write strobe
- m_writedata  out  32  master write data
- m_waitrequest  in  1  master stall; tie to 0 for the PWM slave

## Operation
Slave register map:
- 0 CONTROL (R/W)
  - bit0 start: write-1 pulse, reads 0
  - bit1 abort: write-1 pulse, reads 0
  - bit2 auto_enable
  - bit3 irq_en
- 1 STATUS (R)
  - bit0 busy
  - bit1 done, sticky; writing 1 to bit1 at address 1 clears it
- 2 TARGET (R/W)
- 3 STEP (R/W)
- 4 INTERVAL (R/W)
- 5 CURRENT (R/W)
  - Last value written to PWM COMPARE.
  - Writes are accepted only while idle and are ignored while busy.
- 6, 7: read 0; writes ignored.

State machine: IDLE, EN_WR, WAIT, CMP_WR, DONE.
- IDLE
  - start with auto_enable=1 -> EN_WR.
  - start with auto_enable=0 -> WAIT.
  - On either exit, busy=1, done=0, interval counter loaded with INTERVAL.
- EN_WR
  - Drives m_address=PWM_CTRL_ADDR, m_writedata=1, m_write=1.
  - Held until m_waitrequest=0, then -> WAIT.
- WAIT
  - The interval counter decrements each clock.
  - At 1 -> CMP_WR, with next value latched.
  - If CURRENT == TARGET on entry -> DONE without writing.
- CMP_WR
  - Drives m_address=PWM_CMP_ADDR, m_writedata=next, m_write=1.
  - Held until m_waitrequest=0; then CURRENT <= next and counter reloads.
  - -> DONE if next == TARGET, else -> WAIT.
- DONE
  - One cycle: done=1, busy=0 -> IDLE.

Step arithmetic (unsigned 32-bit, computed on 33 bits, no wrap):
- If CURRENT < TARGET: next = min(CURRENT+STEP, TARGET).
- If CURRENT > TARGET: next = max(CURRENT-STEP, TARGET).
- STEP = 0: next = TARGET, i.e. a single jump.
- INTERVAL = 0: treated as 1.

Busy-time control writes:
- start while busy: retarget. The current TARGET register is used from the next WAIT->CMP_WR decision; the ramp continues from CURRENT; the counter is not reloaded.
- abort: a pending master write completes first. Then -> IDLE, busy=0, done stays 0, CURRENT holds the last written value.
- abort and start in the same write: abort wins.
- TARGET/STEP/INTERVAL writes during a ramp take effect at the next step decision.

## Timing
- Reset values (all asynchronous):
  - Outputs: readdata=0, irq=0, m_write=0, m_address=0, m_writedata=0.
  - State IDLE; busy=0, done=0.
  - CURRENT=RESET_CURRENT, INTERVAL=RESET_INTERVAL, TARGET=STEP=0, CONTROL bits=0.
- readdata is registered from address every clock, so it is valid the cycle after read; read has no side effects.
- start write at cycle T:
  - State leaves IDLE at T+1.
  - With auto_enable: m_write for the EN_WR write asserts at T+1.
  - First COMPARE write asserts INTERVAL clocks after WAIT entry, and INTERVAL clocks apart thereafter (with m_waitrequest=0).
- m_address, m_writedata and m_write are registered and held stable while m_waitrequest=1.
- irq rises the cycle after done sets and falls the cycle after done is cleared or irq_en is cleared.
- Reset mid-ramp: immediate return to reset values; an in-flight master write is dropped.

## Test plan
1. CURRENT=0, TARGET=100, STEP=30, INTERVAL=4, start -> COMPARE writes 30, 60, 90, 100, spaced 4 clocks apart; then done=1, irq=1 (irq_en=1).
2. CURRENT=100, TARGET=10, STEP=50 -> writes 50, then 10, then done. CURRENT=0xFFFFFFF0, TARGET=0xFFFFFFFF, STEP=0x20 -> single write 0xFFFFFFFF, with no wrap.
3. auto_enable=1, STEP=0, TARGET=500 -> CONTROL write of 1 to address 0, then one COMPARE write of 500, then done. m_waitrequest held 3 cycles on each write -> signals stable, with no duplicate writes.
4. Ramp 0->1000 with STEP=100, abort after the third write -> the fourth write never issues; busy=0, done=0, CURRENT=300.
5. Retarget mid-ramp: 0->1000 with STEP=100, at CURRENT=200 write TARGET=250 plus start -> the next write is 250, then done. CURRENT==TARGET at start -> no master write; done within INTERVAL+2 clocks.
6. Assert reset_n low mid-CMP_WR -> m_write=0 and readdata=0 immediately; CURRENT=RESET_CURRENT; a CURRENT write while busy is ignored.

Source files
------------

// File: rtl/unipi_se_pwm_ramp.sv
// unipi_se_pwm_ramp: walks a PWM slave's COMPARE register toward a CPU-programmed target in
// bounded steps at a fixed clock interval, optionally enabling the PWM first; rev 1.0
`default_nettype none

module unipi_se_pwm_ramp #(
  parameter logic [31:0] RESET_CURRENT  = 32'd0,
  parameter logic [31:0] RESET_INTERVAL = 32'd1000,
  parameter logic [1:0]  PWM_CTRL_ADDR  = 2'd0,
  parameter logic [1:0]  PWM_CMP_ADDR   = 2'd2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [1:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EN_WR  = 3'd1,
    S_WAIT   = 3'd2,
    S_CMP_WR = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // One bounded step from cur toward tgt; the 33-bit sum keeps an overshoot near 2^32 from wrapping.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] stp);
    logic [32:0] sum;
    logic [31:0] gap;
    sum         = {1'b0, cur} + {1'b0, stp};
    gap         = cur - tgt;
    step_toward = tgt;
    if (stp != 32'd0) begin
      if (cur < tgt) begin
        if (sum < {1'b0, tgt}) step_toward = sum[31:0];
      end else if (cur > tgt) begin
        if (stp < gap) step_toward = cur - stp;
      end
    end
  endfunction

  state_t      state_q, state_d;
  logic [31:0] target_q, step_q, interval_q;
  logic [31:0] current_q, current_d;
  logic [31:0] next_q, next_d;
  logic [31:0] cnt_q, cnt_d;
  logic        auto_enable_q, irq_en_q;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        m_write_q, m_write_d;
  logic [1:0]  m_address_q, m_address_d;
  logic [31:0] m_writedata_q, m_writedata_d;
  logic [31:0] readdata_q, readdata_d;
  logic        irq_q;

  logic        ctrl_wr, start_req, abort_req, busy, unused_read;
  logic [31:0] ival_eff, step_from_cur, step_from_next;

  assign unused_read    = read;
  assign ctrl_wr        = write && (address == 3'd0);
  assign abort_req      = ctrl_wr && writedata[1];
  assign start_req      = ctrl_wr && writedata[0] && !writedata[1];
  assign busy           = (state_q == S_EN_WR) || (state_q == S_WAIT) || (state_q == S_CMP_WR);
  assign ival_eff       = (interval_q == 32'd0) ? 32'd1 : interval_q;
  assign step_from_cur  = step_toward(current_q, target_q, step_q);
  assign step_from_next = step_toward(next_q, target_q, step_q);

  always_comb begin
    state_d       = state_q;
    current_d     = current_q;
    next_d        = next_q;
    cnt_d         = cnt_q;
    done_d        = done_q;
    abort_d       = abort_q;
    m_write_d     = m_write_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;

    if (write && (address == 3'd1) && writedata[1]) done_d = 1'b0;
    if (!busy && write && (address == 3'd5)) current_d = writedata;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        abort_d = 1'b0;
        if (start_req) begin
          done_d = 1'b0;
          cnt_d  = ival_eff;
          if (writedata[2]) begin
            state_d       = S_EN_WR;
            m_write_d     = 1'b1;
            m_address_d   = PWM_CTRL_ADDR;
            m_writedata_d = 32'd1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_EN_WR: begin
        if (abort_req) abort_d = 1'b1;
        if (!m_waitrequest) begin
          m_write_d = 1'b0;
          state_d   = (abort_q || abort_req) ? S_IDLE : S_WAIT;
        end
      end

      S_WAIT: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else if (current_q == target_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (cnt_q <= 32'd1) begin
          state_d       = S_CMP_WR;
          next_d        = step_from_cur;
          m_write_d     = 1'b1;
          m_address_d   = PWM_CMP_ADDR;
          m_writedata_d = step_from_cur;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_CMP_WR: begin
        if (abort_req) abort_d = 1'b1;
        if (!m_waitrequest) begin
          current_d = next_q;
          if (abort_q || abort_req) begin
            m_write_d = 1'b0;
            state_d   = S_IDLE;
          end else if (next_q == target_q) begin
            m_write_d = 1'b0;
            state_d   = S_DONE;
            done_d    = 1'b1;
          end else if (ival_eff == 32'd1) begin
            // Back-to-back steps: keep the strobe up and present the following value directly.
            next_d        = step_from_next;
            m_writedata_d = step_from_next;
          end else begin
            // The accepting cycle counts as the first clock of the next interval.
            m_write_d = 1'b0;
            cnt_d     = ival_eff - 32'd1;
            state_d   = S_WAIT;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    case (address)
      3'd0:    readdata_d = {28'd0, irq_en_q, auto_enable_q, 2'b00};
      3'd1:    readdata_d = {30'd0, done_q, busy};
      3'd2:    readdata_d = target_q;
      3'd3:    readdata_d = step_q;
      3'd4:    readdata_d = interval_q;
      3'd5:    readdata_d = current_q;
      default: readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      current_q     <= RESET_CURRENT;
      next_q        <= 32'd0;
      cnt_q         <= 32'd0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= 2'd0;
      m_writedata_q <= 32'd0;
      readdata_q    <= 32'd0;
      irq_q         <= 1'b0;
      target_q      <= 32'd0;
      step_q        <= 32'd0;
      interval_q    <= RESET_INTERVAL;
      auto_enable_q <= 1'b0;
      irq_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      current_q     <= current_d;
      next_q        <= next_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      readdata_q    <= readdata_d;
      irq_q         <= done_q & irq_en_q;
      if (ctrl_wr) begin
        auto_enable_q <= writedata[2];
        irq_en_q      <= writedata[3];
      end
      if (write && (address == 3'd2)) target_q   <= writedata;
      if (write && (address == 3'd3)) step_q     <= writedata;
      if (write && (address == 3'd4)) interval_q <= writedata;
    end
  end

  assign readdata    = readdata_q;
  assign irq         = irq_q;
  assign m_write     = m_write_q;
  assign m_address   = m_address_q;
  assign m_writedata = m_writedata_q;

endmodule

`default_nettype wire
